// File: rtl/fmt_pkg.sv
// Shared types and constants for the sensor value formatter: FSM states,
// datapath widths, iteration counts, sensor modes and default scaling.
package fmt_pkg;

   localparam int DATA_W     = 16;
   localparam int COEF_W     = 11;
   localparam int MAG_W      = 14;
   localparam int BCD_W      = 16;
   localparam int MUL_CYCLES = 16;
   localparam int BCD_CYCLES = 14;

   localparam logic MODE_TEMP = 1'b0;
   localparam logic MODE_HUM  = 1'b1;

   localparam int DEF_TEMP_K      = 2000;
   localparam int DEF_TEMP_OFFSET = 500;
   localparam int DEF_HUM_K       = 1000;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      SCALE,
      BCD,
      DONE
   } fmt_state_t;

endpackage

// File: rtl/sensor_value_formatter_if.sv
// Sample-in / formatted-result-out bundle between the AHT20 controller,
// the formatter and the seven-segment display driver.
interface sensor_value_formatter_if;
   import fmt_pkg::*;

   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic              sample_mode;
   logic              busy;
   logic              out_valid;
   logic [BCD_W-1:0]  bcd_out;
   logic              negative;
   logic [7:0]        drop_count;

   modport master (
      output sample_valid, sample_data, sample_mode,
      input  busy, out_valid, bcd_out, negative, drop_count
   );

   modport slave (
      input  sample_valid, sample_data, sample_mode,
      output busy, out_valid, bcd_out, negative, drop_count
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift (with add-3 correction) per
// clock; the first shift happens on the start edge, done pulses after the last.
module bin2bcd_seq
   import fmt_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [MAG_W-1:0] bin_in,
   output logic             done,
   output logic [BCD_W-1:0] bcd_out
);

   logic [BCD_W-1:0] bcd_p0;
   logic [MAG_W-1:0] bin_p0;
   logic [3:0]       cnt;
   logic             active;

   function automatic logic [BCD_W+MAG_W-1:0] dabble(input logic [BCD_W-1:0] bcd,
                                                     input logic [MAG_W-1:0] bin);
      logic [BCD_W-1:0] adj;
      for (int i = 0; i < BCD_W / 4; i++) begin
         adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      end
      return {adj, bin} << 1;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         active <= 1'b0;
         cnt    <= '0;
         done   <= 1'b0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= 4'd1;
         done   <= 1'b0;
      end else if (active) begin
         cnt <= cnt + 4'd1;
         if (cnt == 4'(BCD_CYCLES - 1)) begin
            active <= 1'b0;
            done   <= 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

   // shift register stage: BCD digits above, remaining binary bits below
   always_ff @(posedge clock) begin
      if (start) begin
         {bcd_p0, bin_p0} <= dabble('0, bin_in);
      end else if (active) begin
         {bcd_p0, bin_p0} <= dabble(bcd_p0, bin_p0);
      end
   end

   assign bcd_out = bcd_p0;

endmodule

// File: rtl/sensor_value_formatter.sv
// Scales a raw AHT20 word to tenths of degC / %RH and emits sign + 4 BCD digits.
// Optional build macro FMT_DROP_COUNT_EN enables the saturating drop counter.
module sensor_value_formatter
   import fmt_pkg::*;
#(
   parameter int TEMP_K      = DEF_TEMP_K,
   parameter int TEMP_OFFSET = DEF_TEMP_OFFSET,
   parameter int HUM_K       = DEF_HUM_K
) (
   input  logic                    clock,
   input  logic                    reset,
   sensor_value_formatter_if.slave fmt
);

   fmt_state_t state, state_nxt;

   logic [DATA_W+COEF_W:0] prod_p0;
   logic [COEF_W-1:0]      coef_p0;
   logic                   mode_p0;
   logic [3:0]             mul_cnt;
   logic                   neg_p1;

   logic signed [COEF_W:0] val_p1;
   logic [MAG_W-1:0]       mag_p1;

   logic                   busy;
   logic                   out_valid;
   logic                   accept;
   logic                   bcd_start;
   logic                   bcd_done;
   logic [BCD_W-1:0]       bcd_res;
   logic [BCD_W-1:0]       bcd_q;
   logic                   neg_q;

   // One multiplier bit per call: add coefficient to the upper half when the
   // current LSB is set, then shift the whole accumulator right.
   function automatic logic [DATA_W+COEF_W:0] mul_step(input logic [DATA_W+COEF_W:0] p,
                                                       input logic [COEF_W-1:0]     k);
      logic [COEF_W:0] hi;
      hi = p[DATA_W+COEF_W:DATA_W] + (p[0] ? {1'b0, k} : '0);
      return {1'b0, hi, p[DATA_W-1:1]};
   endfunction

   function automatic logic signed [COEF_W:0] scale_value(input logic [COEF_W-1:0] q,
                                                          input logic              mode);
      logic signed [COEF_W:0] v;
      v = $signed({1'b0, q});
      if (mode == MODE_TEMP) begin
         v = v - (COEF_W + 1)'(TEMP_OFFSET);
      end
      return v;
   endfunction

   function automatic logic [MAG_W-1:0] abs_mag(input logic signed [COEF_W:0] v);
      logic [COEF_W:0] m;
      m = v[COEF_W] ? $unsigned(-v) : $unsigned(v);
      return {{(MAG_W - COEF_W - 1){1'b0}}, m};
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fmt.sample_valid) state_nxt = MUL;
         MUL:     if (mul_cnt == 4'(MUL_CYCLES - 1)) state_nxt = SCALE;
         SCALE:   state_nxt = BCD;
         BCD:     if (bcd_done) state_nxt = DONE;
         DONE:    state_nxt = fmt.sample_valid ? MUL : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      out_valid = 1'b0;
      bcd_start = 1'b0;
      case (state)
         MUL, BCD: busy = 1'b1;
         SCALE: begin
            busy      = 1'b1;
            bcd_start = 1'b1;
         end
         DONE:     out_valid = 1'b1;
         default:  ;
      endcase
   end

   assign accept = fmt.sample_valid && !busy;

   // p0: capture and multiply
   always_ff @(posedge clock) begin
      if (accept) begin
         prod_p0 <= {{(COEF_W + 1){1'b0}}, fmt.sample_data};
         coef_p0 <= (fmt.sample_mode == MODE_HUM) ? COEF_W'(HUM_K) : COEF_W'(TEMP_K);
         mode_p0 <= fmt.sample_mode;
      end else if (state == MUL) begin
         prod_p0 <= mul_step(prod_p0, coef_p0);
      end
      if (state == SCALE) begin
         neg_p1 <= val_p1[COEF_W];
      end
   end

   // p1: offset, sign and magnitude of the scaled product
   always_comb begin
      val_p1 = scale_value(prod_p0[DATA_W+COEF_W-1:DATA_W], mode_p0);
      mag_p1 = abs_mag(val_p1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mul_cnt <= '0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
      end else begin
         if (accept) begin
            mul_cnt <= '0;
         end else if (state == MUL) begin
            mul_cnt <= mul_cnt + 4'd1;
         end
         if (state == BCD && bcd_done) begin
            bcd_q <= bcd_res;
            neg_q <= neg_p1;
         end
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clock   (clock),
      .reset   (reset),
      .start   (bcd_start),
      .bin_in  (mag_p1),
      .done    (bcd_done),
      .bcd_out (bcd_res)
   );

`ifdef FMT_DROP_COUNT_EN
   logic [7:0] drop_cnt;

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (fmt.sample_valid && busy) begin
         drop_cnt <= sat_inc(drop_cnt);
      end
   end

   assign fmt.drop_count = drop_cnt;
`else
   assign fmt.drop_count = 8'h00;
`endif

   assign fmt.busy      = busy;
   assign fmt.out_valid = out_valid;
   assign fmt.bcd_out   = bcd_q;
   assign fmt.negative  = neg_q;

endmodule

// File: tb/tb_sensor_value_formatter.sv
// Bench for sensor_value_formatter: spec vector table, back-to-back/drop,
// reset abort and mode-latch sequences, plus randomized samples vs. a model.
module tb_sensor_value_formatter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   sensor_value_formatter_if bus();

   sensor_value_formatter dut (
      .clock (clk),
      .reset (rst),
      .fmt   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] raw;
      logic        mode;
      logic [15:0] exp_bcd;
      logic        exp_neg;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain arithmetic from the scaling rules, decimal digits by division.
   function automatic logic [16:0] model(input logic [15:0] raw, input logic mode);
      int q, v, m;
      logic [15:0] bcd;
      q = (int'(raw) * (mode ? 1000 : 2000)) >>> 16;
      v = mode ? q : q - 500;
      m = (v < 0) ? -v : v;
      bcd = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
      return {(v < 0), bcd};
   endfunction

   task automatic accept_sample(input logic [15:0] raw, input logic mode);
      bus.sample_valid = 1'b1;
      bus.sample_data  = raw;
      bus.sample_mode  = mode;
      tick();
      bus.sample_valid = 1'b0;
   endtask

   // lat counts edges from the accept edge (which is edge 1); bounded at 40
   task automatic wait_out(input int start, output int lat);
      lat = start;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   vec_t        vecs[6];
   int          lat;
   int          pulses;
   logic [16:0] exp;
   logic [15:0] held;
   logic [15:0] r_raw;
   logic        r_mode;
   logic [7:0]  exp_drop;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      total = 0;
      bad   = 0;
`ifdef FMT_DROP_COUNT_EN
      exp_drop = 8'd1;
`else
      exp_drop = 8'd0;
`endif
      vecs[0] = '{raw: 16'h0000, mode: 1'b0, exp_bcd: 16'h0500, exp_neg: 1'b1};
      vecs[1] = '{raw: 16'h4000, mode: 1'b0, exp_bcd: 16'h0000, exp_neg: 1'b0};
      vecs[2] = '{raw: 16'hFFFF, mode: 1'b0, exp_bcd: 16'h1499, exp_neg: 1'b0};
      vecs[3] = '{raw: 16'h8000, mode: 1'b1, exp_bcd: 16'h0500, exp_neg: 1'b0};
      vecs[4] = '{raw: 16'hFFFF, mode: 1'b1, exp_bcd: 16'h0999, exp_neg: 1'b0};
      vecs[5] = '{raw: 16'h0000, mode: 1'b0, exp_bcd: 16'h0500, exp_neg: 1'b1};

      bus.sample_valid = 1'b0;
      bus.sample_data  = 16'h0000;
      bus.sample_mode  = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      check("reset_busy", {31'b0, bus.busy}, 32'd0);
      check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("reset_bcd", {16'b0, bus.bcd_out}, 32'h0);
      check("reset_neg", {31'b0, bus.negative}, 32'd0);
      check("reset_drop", {24'b0, bus.drop_count}, 32'd0);
      rst = 1'b0;
      tick();

      // spec vector table
      for (int i = 0; i < 6; i++) begin
         accept_sample(vecs[i].raw, vecs[i].mode);
         check($sformatf("vec%0d_busy", i), {31'b0, bus.busy}, 32'd1);
         wait_out(1, lat);
         check($sformatf("vec%0d_latency", i), lat, 32);
         check($sformatf("vec%0d_bcd", i), {16'b0, bus.bcd_out}, {16'b0, vecs[i].exp_bcd});
         check($sformatf("vec%0d_neg", i), {31'b0, bus.negative}, {31'b0, vecs[i].exp_neg});
         check($sformatf("vec%0d_busy_done", i), {31'b0, bus.busy}, 32'd0);
         tick();
         check($sformatf("vec%0d_pulse_end", i), {31'b0, bus.out_valid}, 32'd0);
         check($sformatf("vec%0d_hold", i), {16'b0, bus.bcd_out}, {16'b0, vecs[i].exp_bcd});
         tick();
      end

      // back-to-back accept on the out_valid cycle, then a dropped sample
      accept_sample(16'hFFFF, 1'b0);
      wait_out(1, lat);
      check("b2b_first_bcd", {16'b0, bus.bcd_out}, 32'h1499);
      accept_sample(16'h8000, 1'b1);
      check("b2b_second_busy", {31'b0, bus.busy}, 32'd1);
      tick();
      tick();
      tick();
      accept_sample(16'h0000, 1'b0);
      check("b2b_hold_mid", {16'b0, bus.bcd_out}, 32'h1499);
      wait_out(5, lat);
      check("b2b_latency", lat, 32);
      check("b2b_bcd", {16'b0, bus.bcd_out}, 32'h0500);
      check("b2b_neg", {31'b0, bus.negative}, 32'd0);
      check("b2b_drop_count", {24'b0, bus.drop_count}, {24'b0, exp_drop});
      tick();
      tick();
      check("b2b_no_extra", {31'b0, bus.out_valid}, 32'd0);

      // reset at clock 10 of a conversion
      accept_sample(16'hFFFF, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      rst = 1'b1;
      #2;
      check("abort_busy", {31'b0, bus.busy}, 32'd0);
      check("abort_bcd", {16'b0, bus.bcd_out}, 32'h0);
      check("abort_neg", {31'b0, bus.negative}, 32'd0);
      check("abort_drop", {24'b0, bus.drop_count}, 32'd0);
      tick();
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.out_valid) pulses++;
      end
      check("abort_no_pulse", pulses, 0);

      // mode changes after accept must not affect the result
      accept_sample(16'h8000, 1'b0);
      bus.sample_mode = 1'b1;
      bus.sample_data = 16'h1234;
      wait_out(1, lat);
      check("modeflip_latency", lat, 32);
      check("modeflip_bcd", {16'b0, bus.bcd_out}, 32'h0500);
      check("modeflip_neg", {31'b0, bus.negative}, 32'd0);
      tick();

      // randomized samples against the reference model
      for (int n = 0; n < 30; n++) begin
         r_raw  = 16'($urandom);
         r_mode = 1'($urandom_range(0, 1));
         exp    = model(r_raw, r_mode);
         accept_sample(r_raw, r_mode);
         bus.sample_mode = ~r_mode;
         wait_out(1, lat);
         check($sformatf("rnd%0d_latency", n), lat, 32);
         check($sformatf("rnd%0d_bcd raw=%0h mode=%0d", n, r_raw, r_mode),
               {16'b0, bus.bcd_out}, {16'b0, exp[15:0]});
         check($sformatf("rnd%0d_neg", n), {31'b0, bus.negative}, {31'b0, exp[16]});
         held = bus.bcd_out;
         for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            tick();
            check($sformatf("rnd%0d_hold", n), {16'b0, bus.bcd_out}, {16'b0, held});
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
